// File: rtl/s2p_pkg.sv
// Shared types for the serial-to-parallel receiver: FSM state encoding and parity sense.
package s2p_pkg;
  typedef enum logic {RX_DATA, RX_PAR} s2p_state_t;
  localparam logic PARITY_EVEN = 1'b0;
endpackage

// File: rtl/s2p_out_buf.sv
// One-entry valid/ready holding register for received words; reports words it had to drop.
module s2p_out_buf
  import s2p_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] word,
  input  logic         perr,
  input  logic         push,
  input  logic         DREADY,
  output logic [N-1:0] DOUT,
  output logic         DVALID,
  output logic         PERR,
  output logic         drop
);

  logic pop;

  assign pop  = DVALID & DREADY;
  assign drop = push & DVALID & ~DREADY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
      PERR   <= 1'b0;
    end else if (push && (!DVALID || pop)) begin
      DOUT   <= word;
      PERR   <= perr;
      DVALID <= 1'b1;
    end else if (pop) begin
      // DOUT keeps its last value after the pop
      DVALID <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// LSB-first serial receiver assembling N-bit words into a one-entry valid/ready buffer.
// Build with S2P_PARITY_EN to expect a trailing even-parity bit per word.
module serial_to_parallel_rx
  import s2p_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         SIN,
  input  logic         BIT_EN,
  input  logic         SYNC,
  input  logic         DREADY,
  input  logic         CLR_OVR,
  output logic [N-1:0] DOUT,
  output logic         DVALID,
  output logic         OVERRUN,
  output logic         PERR
);

  localparam int CW = $clog2(N + 1);

  s2p_state_t   state, state_n, st_base;
  logic [N-1:0] sr, sr_n, sr_base, word;
  logic [CW-1:0] cnt, cnt_n, cnt_base;
  logic         push, perr_w, drop;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= RX_DATA;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    // SYNC realigns first, so a coincident strobe becomes bit 0 of the new word
    st_base  = SYNC ? RX_DATA : state;
    sr_base  = SYNC ? '0 : sr;
    cnt_base = SYNC ? '0 : cnt;
    state_n  = st_base;
    sr_n     = sr_base;
    cnt_n    = cnt_base;
    push     = 1'b0;
    word     = sr_base;
    perr_w   = 1'b0;
    if (BIT_EN) begin
      case (st_base)
        RX_DATA: begin
          sr_n = {SIN, sr_base[N-1:1]};
          if (cnt_base == CW'(N - 1)) begin
`ifdef S2P_PARITY_EN
            cnt_n   = CW'(N);
            state_n = RX_PAR;
`else
            cnt_n = '0;
            push  = 1'b1;
            word  = sr_n;
`endif
          end else begin
            cnt_n = cnt_base + 1'b1;
          end
        end
        default: begin
`ifdef S2P_PARITY_EN
          push    = 1'b1;
          word    = sr_base;
          perr_w  = ((^sr_base) ^ SIN) != PARITY_EVEN;
          cnt_n   = '0;
          state_n = RX_DATA;
`else
          state_n = RX_DATA;
`endif
        end
      endcase
    end
  end

  s2p_out_buf #(.N(N)) u_out_buf (
    .CLK    (CLK),
    .RESET  (RESET),
    .word   (word),
    .perr   (perr_w),
    .push   (push),
    .DREADY (DREADY),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .PERR   (PERR),
    .drop   (drop)
  );

  // A drop on the same edge as CLR_OVR leaves the flag set
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        OVERRUN <= 1'b0;
    else if (drop)    OVERRUN <= 1'b1;
    else if (CLR_OVR) OVERRUN <= 1'b0;
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx (N=8): directed scenarios plus a randomized run against a bit-list model.
module tb_serial_to_parallel_rx;

`ifdef S2P_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SIN = 1'b0;
  logic       BIT_EN = 1'b0;
  logic       SYNC = 1'b0;
  logic       DREADY = 1'b0;
  logic       CLR_OVR = 1'b0;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       OVERRUN;
  logic       PERR;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model: bits gathered since the last realign, plus buffer state
  int         m_cnt;
  logic [8:0] m_bits;
  logic       m_dv;
  logic [7:0] m_dout;
  logic       m_perr;
  logic       m_ovr;

  serial_to_parallel_rx #(.N(8)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SIN     (SIN),
    .BIT_EN  (BIT_EN),
    .SYNC    (SYNC),
    .DREADY  (DREADY),
    .CLR_OVR (CLR_OVR),
    .DOUT    (DOUT),
    .DVALID  (DVALID),
    .OVERRUN (OVERRUN),
    .PERR    (PERR)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_cnt = 0; m_bits = '0; m_dv = 0; m_dout = '0; m_perr = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    logic done, dropped;
    done = 0; dropped = 0;
    if (RESET) begin
      model_reset();
      return;
    end
    if (SYNC) begin m_cnt = 0; m_bits = '0; end
    if (BIT_EN) begin
      m_bits[m_cnt] = SIN;
      m_cnt = m_cnt + 1;
      if (m_cnt == FRAME) done = 1;
    end
    if (done) begin
      if (!m_dv || DREADY) begin
        m_dout = m_bits[7:0];
`ifdef S2P_PARITY_EN
        m_perr = ^m_bits;
`else
        m_perr = 1'b0;
`endif
        m_dv = 1;
      end else begin
        dropped = 1;
      end
      m_cnt = 0; m_bits = '0;
    end else if (m_dv && DREADY) begin
      m_dv = 0;
    end
    if (dropped) m_ovr = 1;
    else if (CLR_OVR) m_ovr = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pop();
    BIT_EN = 0; DREADY = 1; tick(); DREADY = 0;
  endtask

  // Sends one frame; saw_valid reports DVALID seen high before the final strobe's edge
  task automatic send_frame(input logic [7:0] w, input int gap_max, input logic par_flip,
                            input logic rdy_last, output logic saw_valid);
    logic [8:0] f;
    int g;
    f = {(^w) ^ par_flip, w};
    saw_valid = 0;
    for (int i = 0; i < FRAME; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
      for (int k = 0; k < g; k++) begin
        BIT_EN = 0; DREADY = 0; tick();
        if (DVALID) saw_valid = 1;
      end
      BIT_EN = 1; SIN = f[i]; DREADY = rdy_last && (i == FRAME - 1);
      tick();
      if (DVALID && i != FRAME - 1) saw_valid = 1;
    end
    BIT_EN = 0; DREADY = 0;
  endtask

  task automatic test_reset();
    RESET = 1; tick(); tick(); RESET = 0; tick();
    tests_run++;
    if ({DOUT, DVALID, OVERRUN, PERR} !== 11'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got DOUT=%h DVALID=%b OVERRUN=%b PERR=%b, want all 0", DOUT, DVALID, OVERRUN, PERR);
    end
  endtask

  task automatic test_basic();
    logic sv;
    send_frame(8'hA5, 0, 0, 0, sv);
    tests_run++;
    if (sv !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b want 0", sv); end
    tests_run++;
    if (DOUT !== 8'hA5 || DVALID !== 1'b1) begin
      tests_failed++; $display("FAIL basic_word: got %h/%b want a5/1", DOUT, DVALID);
    end
    tests_run++;
    if (OVERRUN !== 1'b0 || PERR !== 1'b0) begin
      tests_failed++; $display("FAIL basic_flags: got ovr=%b perr=%b want 0/0", OVERRUN, PERR);
    end
  endtask

  task automatic test_gaps();
    logic sv;
    pop();
    tests_run++;
    if (DVALID !== 1'b0) begin tests_failed++; $display("FAIL gaps_pop: got DVALID=%b want 0", DVALID); end
    send_frame(8'hA5, 3, 0, 0, sv);
    tests_run++;
    if (sv !== 1'b0) begin tests_failed++; $display("FAIL gaps_early_valid: got %b want 0", sv); end
    tests_run++;
    if (DOUT !== 8'hA5 || DVALID !== 1'b1 || OVERRUN !== 1'b0) begin
      tests_failed++; $display("FAIL gaps_word: got %h/%b/%b want a5/1/0", DOUT, DVALID, OVERRUN);
    end
  endtask

  task automatic test_overrun();
    logic sv;
    pop();
    send_frame(8'h3C, 0, 0, 0, sv);
    send_frame(8'hC3, 1, 0, 0, sv);
    tests_run++;
    if (DOUT !== 8'h3C || DVALID !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_keep: got %h/%b want 3c/1", DOUT, DVALID);
    end
    tests_run++;
    if (OVERRUN !== 1'b1) begin tests_failed++; $display("FAIL overrun_set: got %b want 1", OVERRUN); end
    tick();
    tests_run++;
    if (OVERRUN !== 1'b1) begin tests_failed++; $display("FAIL overrun_sticky: got %b want 1", OVERRUN); end
    CLR_OVR = 1; tick(); CLR_OVR = 0;
    tests_run++;
    if (OVERRUN !== 1'b0) begin tests_failed++; $display("FAIL overrun_clear: got %b want 0", OVERRUN); end
  endtask

  task automatic test_back_to_back();
    logic sv;
    pop();
    send_frame(8'h11, 0, 0, 0, sv);
    tests_run++;
    if (DOUT !== 8'h11) begin tests_failed++; $display("FAIL b2b_first: got %h want 11", DOUT); end
    send_frame(8'h22, 0, 0, 1, sv);
    tests_run++;
    if (DVALID !== 1'b1 || DOUT !== 8'h22 || OVERRUN !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_second: got %h/%b/%b want 22/1/0", DOUT, DVALID, OVERRUN);
    end
  endtask

  task automatic test_realign();
    logic sv;
    pop();
    for (int i = 0; i < 4; i++) begin BIT_EN = 1; SIN = 1'b1; tick(); end
    BIT_EN = 0;
    #3 RESET = 1;
    #1;
    tests_run++;
    if ({DOUT, DVALID, OVERRUN, PERR} !== 11'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got DOUT=%h DVALID=%b OVERRUN=%b PERR=%b want all 0", DOUT, DVALID, OVERRUN, PERR);
    end
    @(posedge CLK); #1;
    model_reset();
    RESET = 0;
    send_frame(8'h5A, 0, 0, 0, sv);
    tests_run++;
    if (DOUT !== 8'h5A || DVALID !== 1'b1) begin
      tests_failed++; $display("FAIL reset_resume: got %h/%b want 5a/1", DOUT, DVALID);
    end
    pop();
    for (int i = 0; i < 4; i++) begin BIT_EN = 1; SIN = 1'b1; tick(); end
    BIT_EN = 0; SYNC = 1; tick(); SYNC = 0;
    send_frame(8'h5A, 0, 0, 0, sv);
    tests_run++;
    if (DOUT !== 8'h5A || DVALID !== 1'b1 || OVERRUN !== 1'b0) begin
      tests_failed++; $display("FAIL sync_resume: got %h/%b/%b want 5a/1/0", DOUT, DVALID, OVERRUN);
    end
  endtask

`ifdef S2P_PARITY_EN
  task automatic test_parity();
    logic sv;
    pop();
    send_frame(8'h07, 0, 0, 0, sv);
    tests_run++;
    if (DOUT !== 8'h07 || PERR !== 1'b0) begin
      tests_failed++; $display("FAIL parity_good: got %h/%b want 07/0", DOUT, PERR);
    end
    pop();
    send_frame(8'h07, 0, 1, 0, sv);
    tests_run++;
    if (DOUT !== 8'h07 || PERR !== 1'b1 || DVALID !== 1'b1) begin
      tests_failed++; $display("FAIL parity_bad: got %h/%b/%b want 07/1/1", DOUT, PERR, DVALID);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      BIT_EN  = ($urandom_range(3, 0) != 0);
      SIN     = 1'($urandom);
      DREADY  = ($urandom_range(3, 0) == 0);
      SYNC    = ($urandom_range(63, 0) == 0);
      CLR_OVR = ($urandom_range(31, 0) == 0);
      tick();
      tests_run++;
      if (DOUT !== m_dout || DVALID !== m_dv || OVERRUN !== m_ovr || PERR !== m_perr) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 DOUT, DVALID, OVERRUN, PERR, m_dout, m_dv, m_ovr, m_perr);
      end
    end
    BIT_EN = 0; SYNC = 0; CLR_OVR = 0; DREADY = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_realign();
`ifdef S2P_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
